// File: rtl/float_pkg.sv
// Shared single-precision constants, FSM encoding and field packing for the
// integer-to-float datapath (CLZ stage, normalizer, later FP units).
package float_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } norm_state_t;

  function automatic logic [EXP_W+MANT_W:0] pack_float(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [MANT_W-1:0] mant
  );
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/int_to_float_normalizer_round.sv
// Round-to-nearest-even on a truncated mantissa; carry out means the mantissa
// wrapped to zero and the exponent must be bumped by one.
module fp_round_rne #(
  parameter int MANT_W = 23
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_carry,
  output logic              o_inexact
);

  logic w_round_up;
  logic [MANT_W:0] w_sum;

  // Exact ties go up only when that makes the kept LSB even.
  assign w_round_up = i_guard & (i_sticky | i_mant[0]);
  assign w_sum      = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_round_up};
  assign o_mant     = w_sum[MANT_W-1:0];
  assign o_carry    = w_sum[MANT_W];
  assign o_inexact  = i_guard | i_sticky;

endmodule

// File: rtl/int_to_float_normalizer.sv
// Multi-cycle int32 -> IEEE-754 single converter: left-normalizes by a supplied
// CLZ in bounded steps, rounds to nearest-even and holds the result under backpressure.
module int_to_float_normalizer
  import float_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 8,
  parameter int FLOAT_BIAS = float_pkg::FLOAT_BIAS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_signed,
  input  logic [5:0]       in_clz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float,
  output logic             out_inexact
);

  localparam logic [5:0]       STEP_L  = 6'(SHIFT_STEP);
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(FLOAT_BIAS + 31);

  norm_state_t      r_state;
  logic             r_sign;
  logic [WIDTH-1:0] r_mag;
  logic [5:0]       r_rem;
  logic [5:0]       r_clz;
  logic [31:0]      r_float;
  logic             r_inexact;
  logic             r_in_ready;
  logic             r_out_valid;

  logic              w_in_sign;
  logic [WIDTH-1:0]  w_in_mag;
  logic [5:0]        w_step;
  logic [EXP_W-1:0]  w_exp_base;
  logic [EXP_W-1:0]  w_exp;
  logic [MANT_W-1:0] w_mant;
  logic              w_carry;
  logic              w_inexact;

  // Two's-complement negate leaves 0x80000000 unchanged, which is the correct magnitude.
  assign w_in_sign = in_signed & in_value[WIDTH-1];
  assign w_in_mag  = w_in_sign ? (~in_value + 1'b1) : in_value;

  assign w_step     = (r_rem > STEP_L) ? STEP_L : r_rem;
  assign w_exp_base = EXP_TOP - {2'b00, r_clz};
  assign w_exp      = w_exp_base + {{(EXP_W-1){1'b0}}, w_carry};

  fp_round_rne #(
    .MANT_W (MANT_W)
  ) u_round (
    .i_mant    (r_mag[30:8]),
    .i_guard   (r_mag[7]),
    .i_sticky  (|r_mag[6:0]),
    .o_mant    (w_mant),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_rem       <= '0;
      r_clz       <= '0;
      r_float     <= '0;
      r_inexact   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= w_in_sign;
            r_mag      <= w_in_mag;
            r_rem      <= in_clz;
            r_clz      <= in_clz;
            r_in_ready <= 1'b0;
            // Any CLZ of 32 or more means a zero magnitude: emit +0 directly.
            if (in_clz[5]) begin
              r_float     <= '0;
              r_inexact   <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_mag <= r_mag << w_step;
          r_rem <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_float     <= pack_float(r_sign, w_exp, w_mant);
          r_inexact   <= w_inexact;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_float   = r_float;
  assign out_inexact = r_inexact;

endmodule

// File: tb/tb_int_to_float_normalizer.sv
// Directed and random checks of the int->float normalizer against a value-level
// reference model (magnitude, MSB position, integer remainder rounding).
module tb_int_to_float_normalizer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_signed;
  logic [5:0]  in_clz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        out_inexact;

  int checks;
  int errors;

  logic [31:0] rv;
  logic        rs;
  logic [5:0]  rc;
  logic [31:0] rf;
  logic        ri;
  int          rl;

  int_to_float_normalizer #(
    .WIDTH      (32),
    .SHIFT_STEP (8),
    .FLOAT_BIAS (127)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_signed   (in_signed),
    .in_clz      (in_clz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_float   (out_float),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic on the magnitude, rounding by remainder vs half.
  task automatic ref_model(input logic [31:0] v, input logic s,
                           output logic [5:0] clz, output logic [31:0] f,
                           output logic inex, output int lat);
    logic             sign;
    longint unsigned  mag, q, r, half;
    int               p, e, sh;
    sign = s & v[31];
    mag  = sign ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
    if (mag == 0) begin
      clz = 6'd32; f = 32'h0; inex = 1'b0; lat = 1;
    end else begin
      p = 31;
      while (((mag >> p) & 64'd1) == 0) p--;
      clz = 6'(31 - p);
      e = 127 + p;
      if (p <= 23) begin
        q = mag << (23 - p);
        inex = 1'b0;
      end else begin
        sh   = p - 23;
        q    = mag >> sh;
        r    = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q++;
        inex = (r != 0);
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e++;
        end
      end
      f = {sign, 8'(e), q[22:0]};
      lat = ((clz == 0) ? 1 : (int'(clz) + 7) / 8) + 2;
    end
  endtask

  task automatic do_job(input string tag, input logic [31:0] v, input logic s,
                        input logic [5:0] clz, input logic [31:0] ef, input logic ei,
                        input int elat, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_value  = v;
    in_signed = s;
    in_clz    = clz;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_ready_busy"}, in_ready, 0);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_float"}, out_float, ef);
    chk({tag, "_inexact"}, out_inexact, ei);
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_value  = $urandom;
      in_signed = 1'b0;
      in_clz    = 6'd0;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_float"}, out_float, ef);
      chk({tag, "_hold_inexact"}, out_inexact, ei);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    in_signed = 1'b0;
    in_clz    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_float", out_float, 0);
    chk("rst_out_inexact", out_inexact, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_job("d2748",   32'd2748,      1'b0, 6'd20, 32'h452BC000, 1'b0, 5, 0);
    do_job("dzero",   32'h0,         1'b0, 6'd32, 32'h00000000, 1'b0, 1, 0);
    do_job("dsat",    32'h0,         1'b1, 6'd45, 32'h00000000, 1'b0, 1, 0);
    do_job("dmin",    32'h80000000,  1'b1, 6'd0,  32'hCF000000, 1'b0, 3, 0);
    do_job("dcarry",  32'hFFFFFFFF,  1'b0, 6'd0,  32'h4F800000, 1'b1, 3, 0);
    do_job("dneg1",   32'hFFFFFFFF,  1'b1, 6'd31, 32'hBF800000, 1'b0, 6, 0);
    do_job("dtieev",  32'h01000001,  1'b0, 6'd7,  32'h4B800000, 1'b1, 3, 0);
    do_job("dtieup",  32'h01000003,  1'b0, 6'd7,  32'h4B800002, 1'b1, 3, 0);

    // Backpressure: result held 10 cycles, competing in_valid ignored.
    ref_model(32'h12345678, 1'b1, rc, rf, ri, rl);
    do_job("bp_hold", 32'h12345678, 1'b1, rc, rf, ri, rl, 10);
    ref_model(32'hFEDCBA98, 1'b1, rc, rf, ri, rl);
    do_job("bp_next", 32'hFEDCBA98, 1'b1, rc, rf, ri, rl, 0);

    // Reset during SHIFT.
    in_valid = 1'b1; in_value = 32'd2748; in_signed = 1'b0; in_clz = 6'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_shift_valid", out_valid, 0);
    chk("rst_shift_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_shift_ready_rel", in_ready, 1);

    // Reset while a result is pending drops out_valid without a clock edge.
    in_valid = 1'b1; in_value = 32'h0; in_signed = 1'b0; in_clz = 6'd32;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_out_pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    do_job("post_rst", 32'd1, 1'b0, 6'd31, 32'h3F800000, 1'b0, 6, 0);

    for (int k = 0; k < 40; k++) begin
      rv = $urandom >> $urandom_range(0, 32);
      rs = 1'($urandom_range(0, 1));
      ref_model(rv, rs, rc, rf, ri, rl);
      do_job($sformatf("rnd%0d", k), rv, rs, rc, rf, ri, rl, (k % 7 == 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
